// File: rtl/double_threshold_ctrl.sv
// Frame sequencer around double_threshold_unit: buffers one frame from an input
// stream, runs the unit once, then streams the thresholded frame downstream.
module double_threshold_ctrl #(
    parameter int HEIGHT   = 5,
    parameter int WIDTH    = 5,
    parameter int IMG_SIZE = HEIGHT * WIDTH,
    parameter int TIMEOUT  = 1024,
    parameter int DATA_W   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_last,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    output logic              dt_enable,
    output logic [DATA_W-1:0] dt_z   [0:IMG_SIZE-1],
    input  logic [DATA_W-1:0] dt_res [0:IMG_SIZE-1],
    input  logic              dt_done,
    output logic              busy,
    output logic              frame_err,
    output logic              timeout,
    output logic [15:0]       frame_count
);
    localparam int IDX_W = (IMG_SIZE > 1) ? $clog2(IMG_SIZE) : 1;
    localparam int TMR_W = $clog2(TIMEOUT);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(IMG_SIZE - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [TMR_W-1:0] TMR_MAX  = TMR_W'(TIMEOUT - 1);
    localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [IDX_W-1:0]  wr_idx;
    logic [IDX_W-1:0]  rd_idx;
    logic [TMR_W-1:0]  timer;
    logic              dt_done_p1;
    logic [DATA_W-1:0] ibuf [0:IMG_SIZE-1];
    logic [DATA_W-1:0] obuf [0:IMG_SIZE-1];

    logic s_fire;
    logic m_fire;
    logic done_rise;

    assign s_fire    = (state == LOAD) && s_valid;
    assign m_fire    = (state == DRAIN) && m_ready;
    // A done level left over from the previous frame must not complete this one.
    assign done_rise = dt_done && !dt_done_p1;
    assign busy      = (state != LOAD);
    assign dt_z      = ibuf;

    always_comb begin
        state_nxt = state;
        s_ready   = 1'b0;
        m_valid   = 1'b0;
        m_data    = '0;
        m_last    = 1'b0;
        dt_enable = 1'b0;
        frame_err = 1'b0;
        timeout   = 1'b0;
        case (state)
            LOAD: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    if (wr_idx == LAST_IDX) begin
                        state_nxt = START;
                        frame_err = !s_last;
                    end else if (s_last) begin
                        frame_err = 1'b1;
                    end
                end
            end
            START: begin
                dt_enable = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: begin
                if (done_rise) begin
                    state_nxt = DRAIN;
                end else if (timer == TMR_MAX) begin
                    timeout   = 1'b1;
                    state_nxt = LOAD;
                end
            end
            DRAIN: begin
                m_valid = 1'b1;
                m_data  = obuf[rd_idx];
                m_last  = (rd_idx == LAST_IDX);
                if (m_ready && (rd_idx == LAST_IDX)) begin
                    state_nxt = LOAD;
                end
            end
            default: state_nxt = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= LOAD;
            wr_idx      <= '0;
            rd_idx      <= '0;
            timer       <= '0;
            dt_done_p1  <= 1'b0;
            frame_count <= '0;
        end else begin
            state      <= state_nxt;
            dt_done_p1 <= dt_done;
            if (s_fire) begin
                wr_idx <= ((wr_idx == LAST_IDX) || s_last) ? '0 : wr_idx + IDX_ONE;
            end
            if (state == START) begin
                timer <= '0;
            end else if (state == WAIT) begin
                timer <= timer + TMR_ONE;
            end
            if (m_fire) begin
                if (rd_idx == LAST_IDX) begin
                    rd_idx      <= '0;
                    frame_count <= frame_count + 16'd1;
                end else begin
                    rd_idx <= rd_idx + IDX_ONE;
                end
            end
        end
    end

    // ibuf only changes in LOAD, so Z is frozen while the unit works on it.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < IMG_SIZE; i++) begin
                ibuf[i] <= '0;
                obuf[i] <= '0;
            end
        end else begin
            if (s_fire) begin
                ibuf[wr_idx] <= s_data;
            end
            if ((state == WAIT) && done_rise) begin
                for (int i = 0; i < IMG_SIZE; i++) begin
                    obuf[i] <= dt_res[i];
                end
            end
        end
    end

endmodule

// File: doc/double_threshold_ctrl.md
# double_threshold_ctrl

Sequencer that wraps `double_threshold_unit` and exposes it as a pixel stream. It buffers one HEIGHT×WIDTH frame from an upstream valid/ready stream (non-maximum-suppression output) and drives it to the unit's `Z` array. It pulses `enable`, waits for `done`, captures `res`, and streams the thresholded frame to the downstream hysteresis stage. Frame-alignment errors and a hung unit are detected and reported.

## Interface

- HEIGHT, 5, image rows (same value given to the unit)
- WIDTH, 5, image columns
- IMG_SIZE, HEIGHT*WIDTH, derived; pixels per frame
- TIMEOUT, 1024, max cycles spent in WAIT before abort (≥2)

- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- s_valid  in  1  upstream pixel valid
- s_ready  out  1  upstream pixel accepted when s_valid&&s_ready
- s_data  in  8  upstream pixel, raster order
- s_last  in  1  marks final pixel of a frame
- m_valid  out  1  downstream pixel valid
- m_ready  in  1  downstream ready
- m_data  out  8  thresholded pixel, raster order
- m_last  out  1  high with the final pixel of a frame
- dt_enable  out  1  to unit `enable`
- dt_z  out  8×IMG_SIZE  to unit `Z`, unpacked array [0:IMG_SIZE-1]
- dt_res  in  8×IMG_SIZE  from unit `res`
- dt_done  in  1  from unit `done`
- busy  out  1  high whenever state≠LOAD
- frame_err  out  1  one-cycle pulse on s_last misalignment
- timeout  out  1  one-cycle pulse on WAIT abort
- frame_count  out  16  frames fully drained; wraps 0xFFFF→0

## Operation

- States: LOAD, START, WAIT, DRAIN.
- LOAD: s_ready=1. Each accepted beat writes ibuf[wr_idx] and increments wr_idx.
  - s_last on a beat with wr_idx<IMG_SIZE-1 (short frame): pulse frame_err, set wr_idx=0, stay in LOAD; the partial frame is discarded.
  - Beat at wr_idx==IMG_SIZE-1: write the pixel, set wr_idx=0, go to START. If s_last=0 on that beat, also pulse frame_err (long frame). Later beats up to and including the stray s_last form the next frame.
- START: dt_enable=1 for exactly this cycle; s_ready=0; WAIT timer cleared. Next state is always WAIT.
- WAIT: dt_enable=0.
  - Completion is a rising edge of dt_done (dt_done=1 and the registered previous dt_done=0), so a stale level from the prior frame is ignored. On the edge: obuf←dt_res (all IMG_SIZE entries), go to DRAIN.
  - If the timer reaches TIMEOUT-1 with no edge: pulse timeout, go to LOAD; the frame is dropped and frame_count is unchanged.
- DRAIN: m_valid=1, m_data=obuf[rd_idx], m_last=(rd_idx==IMG_SIZE-1). On m_valid&&m_ready, rd_idx increments. On the last handshake: rd_idx=0, frame_count+1, go to LOAD. m_data and m_last stay stable while m_ready=0.
- dt_z is driven continuously from ibuf. ibuf is written only in LOAD, so Z is stable from START until the frame is captured.
- Widths: wr_idx and rd_idx are $clog2(IMG_SIZE) bits. The timer is $clog2(TIMEOUT) bits. No arithmetic is performed on pixel values.

## Timing

- Reset (synchronous, checked at a rising edge): state=LOAD, wr_idx=rd_idx=0, timer=0, prev dt_done=0, frame_count=0, s_ready=1 from the first cycle after reset. m_valid, m_last, dt_enable, busy, frame_err and timeout are all 0; m_data=0. ibuf and obuf are cleared to 0.
- Reset during START, WAIT or DRAIN aborts the frame with no pulse on frame_err or timeout.
- Final input beat accepted at edge n: dt_enable=1 during cycle n+1, and WAIT starts at n+2.
- dt_done edge sampled at edge d: m_valid=1 from cycle d+1. With m_ready held high, a frame drains in IMG_SIZE cycles.
- Once DRAIN ends, s_ready=1 in the next cycle.
- Minimum turnaround: IMG_SIZE (load) + 1 (START) + unit latency + 1 + IMG_SIZE (drain) cycles. There is no overlap between loading and draining.
- s_valid during START, WAIT or DRAIN is not accepted (s_ready=0), so no data is lost.
- frame_err and timeout never assert in the same cycle.

## Test plan

- Nominal: feed the 5×5 frame with a ring of 100, centre 255 and zero border, s_last on beat 24. Unit uses HIGH 3/20, LOW 1/20. Expect dt_enable high for exactly one cycle and m_data = 255 at positions 6–8, 11–13 and 16–18, 0 elsewhere. m_last only on beat 24; frame_count=1.
- Weak and zero pixels: a frame with pixels 20, 1 and 38 mixed → outputs 75, 0 and 255 respectively. Stall m_ready low for 3 cycles mid-drain → m_data and m_last held, no pixel duplicated or skipped.
- Short frame: s_last on beat 10 → frame_err pulses once, no dt_enable. A following correct 25-beat frame produces correct output.
- Long frame: s_last absent on beat 24 → frame_err pulses and processing proceeds. Extra beats are taken as the next frame.
- Timeout: use a stub unit that never raises done, with TIMEOUT=16 → timeout pulses 15 cycles into WAIT, state returns to LOAD, frame_count unchanged. Also hold dt_done high across START → not accepted until it falls and rises again.
- Reset mid-DRAIN after 7 beats → m_valid=0 the next cycle, s_ready=1, frame_count=0. The next frame drains from beat 0.
